// File: rtl/cnn_stream_pkg.sv
// Shared types and constants for the CNN accelerator stream checker and
// stream source: the checker FSM states, the throttle LFSR polynomial and
// its default seed, and a one-step LFSR helper.
package cnn_stream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form).
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/exp_ram.sv
// Single write port / synchronous read memory, N words of T bits.
// The read is registered every cycle. On a same-address write and read,
// the read returns the old contents.
//   clk_i      : clock
//   wr_en_i    : write strobe
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_addr_i  : read address, sampled every rising edge
//   rd_data_o  : registered read data
module exp_ram #(
    parameter int T  = 16,
    parameter int N  = 2340,
    parameter int AW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [T-1:0]  wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [T-1:0]  rd_data_o
);

    logic [T-1:0] mem_q [N];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/stream_result_checker.sv
// Result sink for the network output stream. Compares each accepted word,
// in order, against an expected-value RAM, counts mismatches and records
// the first failing index. s_ready can be throttled by a 16-bit LFSR to
// reproduce random backpressure on hardware.
//   clk, reset          : clock, async active-high reset
//   s_data_in/s_valid   : incoming result stream
//   s_ready             : checker accepts the word (never depends on s_valid)
//   exp_wr_*            : expected-RAM write port (ignored while running)
//   throttle_en         : gate s_ready with LFSR bit 0
//   start               : one-cycle pulse, begins a run (ignored while running)
//   busy / done         : run in progress / run complete (held until start)
//   error_count         : mismatches in current/last run
//   first_error_idx     : index of first mismatch, all-ones if none
module stream_result_checker
    import cnn_stream_pkg::*;
#(
    parameter int          T             = 16,
    parameter int          NUMOUTPUTVALS = 2340,
    parameter logic [15:0] LFSR_SEED     = LFSR_DEFAULT_SEED,
    parameter int          AW            = $clog2(NUMOUTPUTVALS),
    parameter int          CW            = $clog2(NUMOUTPUTVALS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [T-1:0] s_data_in,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                exp_wr_en,
    input  logic [AW-1:0]       exp_wr_addr,
    input  logic [T-1:0]        exp_wr_data,
    input  logic                throttle_en,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [CW-1:0]       error_count,
    output logic [AW-1:0]       first_error_idx
);

    // An all-zero LFSR would lock up; substitute 1.
    localparam logic [15:0]   SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [AW-1:0] LAST = AW'(NUMOUTPUTVALS - 1);

    chk_state_t    state_q, state_d;
    logic [AW-1:0] i_q, i_d;
    logic [CW-1:0] err_q, err_d;
    logic [AW-1:0] first_q, first_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [T-1:0]  exp_q;
    logic          hs;
    logic          mism;

    assign s_ready         = (state_q == RUN) && (throttle_en ? lfsr_q[0] : 1'b1);
    assign hs              = s_valid && s_ready;
    assign mism            = $unsigned(s_data_in) != exp_q;
    assign busy            = (state_q == RUN);
    assign done            = (state_q == DONE);
    assign error_count     = err_q;
    assign first_error_idx = first_q;

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        err_d   = err_q;
        first_d = first_q;
        lfsr_d  = lfsr_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    i_d     = '0;
                    err_d   = '0;
                    first_d = '1;
                    lfsr_d  = SEED;
                end
            end
            RUN: begin
                lfsr_d = lfsr_next(lfsr_q);
                if (hs) begin
                    if (mism) begin
                        err_d = err_q + CW'(1);
                        if (err_q == '0) first_d = i_q;
                    end
                    // Wrap on the final word so the RAM is never read
                    // past its last entry; i is reloaded on start anyway.
                    if (i_q == LAST) begin
                        state_d = DONE;
                        i_d     = '0;
                    end else begin
                        i_d = i_q + AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            err_q   <= '0;
            first_q <= '1;
            lfsr_q  <= SEED;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            err_q   <= err_d;
            first_q <= first_d;
            lfsr_q  <= lfsr_d;
        end
    end

    // Reading at i_d keeps exp_q aligned with the current index i, which
    // allows one compare per cycle with no bubbles.
    exp_ram #(.T(T), .N(NUMOUTPUTVALS), .AW(AW)) u_exp_ram (
        .clk_i     (clk),
        .wr_en_i   (exp_wr_en && (state_q != RUN)),
        .wr_addr_i (exp_wr_addr),
        .wr_data_i (exp_wr_data),
        .rd_addr_i (i_d),
        .rd_data_o (exp_q)
    );

endmodule

// File: doc/stream_result_checker.md
# stream_result_checker

Hardware result sink for the CNN accelerator's output stream. It consumes the `m_data_out_y` valid/ready stream of a `multi_*` network and compares every word in order against an expected-value RAM. It counts mismatches, records the first failing index, and can throttle `s_ready` with an LFSR. This lets on-board self-test reproduce the random-backpressure checking that the simulation benches perform.

## Interface
**Parameters**
- `T`, default 16: data word width (signed).
- `NUMOUTPUTVALS`, default 2340: number of words per run.
- `LFSR_SEED`, default 16'hACE1: throttle LFSR reset/restart value. A value of 0 is replaced by 16'h0001.
- `AW`, default `$clog2(NUMOUTPUTVALS)`: index/address width.
- `CW`, default `$clog2(NUMOUTPUTVALS+1)`: error-count width.

**Ports**
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `s_data_in` in T: signed result word from the network.
- `s_valid` in 1: result word valid.
- `s_ready` out 1: checker accepts the word.
- `exp_wr_en` in 1: expected-RAM write strobe.
- `exp_wr_addr` in AW: write address.
- `exp_wr_data` in T: expected value.
- `throttle_en` in 1: gate `s_ready` with the LFSR.
- `start` in 1: one-cycle pulse that begins a run.
- `busy` out 1: a run is in progress.
- `done` out 1: run complete; held high until the next `start`.
- `error_count` out CW: number of mismatches in the current/last run.
- `first_error_idx` out AW: index of the first mismatch; all-ones if there is none.

## Operation
**FSM states: IDLE, RUN, DONE.**
- IDLE
  - `s_ready`=0.
  - Expected-RAM writes are accepted.
  - On `start`: go to RUN, clear index `i`, clear `error_count`, set `first_error_idx` to all-ones, load the LFSR with the seed.
- RUN
  - `busy`=1.
  - `s_ready` = `throttle_en ? lfsr[0] : 1`. It never depends on `s_valid`.
  - On a handshake (`s_valid && s_ready`):
    - Compare `s_data_in` with `exp_q` (the expected word for `i`).
    - On mismatch, increment `error_count`. If `error_count` was 0, latch `first_error_idx = i`.
    - Increment `i`.
  - The handshake with `i == NUMOUTPUTVALS-1` moves the FSM to DONE.
- DONE
  - `s_ready`=0, `done`=1.
  - Expected-RAM writes are accepted.
  - `start`: same as from IDLE (restart), and `done` clears.

**LFSR**
- 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1.
- Advances every cycle in RUN; holds otherwise.

**Arithmetic and comparison**
- Comparison is a full T-bit equality.
- `error_count` cannot overflow because it is at most `NUMOUTPUTVALS` within a run.

**Boundary conditions**
- `exp_wr_en` during RUN is ignored; the RAM is unchanged.
- `start` during RUN is ignored.
- `start` and `exp_wr_en` in the same IDLE cycle: the write takes effect, but word 0 is read in the same cycle, so that write must not target address 0. Bench software writes before starting.
- `reset` mid-run: the FSM returns to IDLE immediately, and all counters and outputs go to reset values. RAM contents are not reset.

## Timing
**Reset values**
- `s_ready`=0, `busy`=0, `done`=0, `error_count`=0, `first_error_idx`='1, state IDLE, LFSR=seed.

**Expected-RAM read path**
- The expected RAM is single-port write / synchronous-read (`NUMOUTPUTVALS` x T).
- Read address = `i_next`, the combinational next value of `i`: 0 on `start`, `i+1` on a handshake, otherwise `i`.
- As a result, `exp_q` always holds `exp[i]` in the cycle `i` is current.
- Full throughput: one accepted word per cycle is sustained with `throttle_en`=0.

**Latency**
- `start` → `s_ready` high on the next cycle (throttle off).
- Final handshake → `done`=1 and `busy`=0 on the next cycle.
- `error_count` and `first_error_idx` update one cycle after the handshake that causes them.

## Structure
- Package `cnn_stream_pkg`: `typedef enum logic [1:0] {IDLE, RUN, DONE} chk_state_t`; LFSR tap constant `16'hB400`; default seed.
- Sub-module `exp_ram` (parameters T, N): synchronous-read, single-write-port memory. It is reusable by the input-side stream source.
- Everything else (FSM, index counter, comparator, LFSR, error registers) lives in the top module.

## Test plan
- **Clean run:** load exp[k]=k for N=2340. Start, and drive `s_data_in`=k with `s_valid` held high and throttle off. Required: 2340 consecutive accepts, `done` one cycle after the last accept, `error_count`=0, `first_error_idx`=12'hFFF.
- **Injected errors:** same run, but words 5, 700 and 2339 are corrupted (XOR 16'h0001). Required: `error_count`=3, `first_error_idx`=5.
- **Throttle:** `throttle_en`=1 with default seed, `s_valid` random. Required: `s_ready` matches the reference LFSR bit-for-bit, no words are lost or duplicated, `error_count`=0.
- **Reset mid-run:** assert reset after 1000 accepts. Required: `s_ready`/`busy` go low asynchronously, `error_count`=0. A restart then checks all 2340 words from index 0.
- **Write while busy:** write exp[10]=16'h7FFF during RUN. Required: the write is ignored and word 10 still matches its original value.
- **Restart from DONE:** issue `start` after a run that ended with `error_count`=3. Required: `done` clears, counters clear, and the second clean run reports 0 errors.
